fir_decimator_fifo: RTL and testbench

//  Downstream stage of the Gaussian FIR. Takes the filter output stream, decimates by DECIM,
//  and buffers decimated samples in a small FIFO with a valid/ready output handshake.

---
 rtl/fir_pkg.sv | 19 +
 rtl/sample_fifo.sv | 66 ++++++
 rtl/fir_decimator_fifo.sv | 98 +++++++++
 tb/tb_fir_decimator_fifo.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
//   Shared definitions for the Gaussian FIR back end.
//   - FIR_WIDTH   : default sample width (matches the FIR output width)
//   - sample_t    : one sample at the default width
//   - is_pow2_ge2 : elaboration-time check for DECIM / DEPTH parameters
// -----------------------------------------------------------------------------
package fir_pkg;

   localparam int FIR_WIDTH = 8;

   typedef logic [FIR_WIDTH-1:0] sample_t;

   // True for 2, 4, 8, ... ; used to reject bad DECIM / DEPTH at elaboration.
   function automatic bit is_pow2_ge2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
//   Small synchronous FIFO with wrap-bit pointers.
//   Ports:
//     clock, nreset   rising-edge clock, asynchronous active-low reset
//     push, wr_data   write request / data (ignored when full unless popping)
//     pop             read request (ignored when empty)
//     rd_data         head entry; when empty, the most recently popped value
//     full, empty     occupancy flags
//     level           occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module sample_fifo
   import fir_pkg::*;
#(
   parameter int WIDTH = FIR_WIDTH,
   parameter int DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     nreset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr, rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] last_q;
   logic             do_push, do_pop;

   assign empty = (wr_ptr == rd_ptr);
   // Same slot, opposite lap: the writer is one full lap ahead.
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level = wr_ptr - rd_ptr;

   assign do_pop  = pop & ~empty;
   // A pop on the same edge frees the slot, so a full FIFO can still accept.
   assign do_push = push & (~full | do_pop);

   // Hold the last popped value while empty so the output does not jump to stale memory.
   assign rd_data = empty ? last_q : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         last_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            last_q <= mem[rd_ptr[AW-1:0]];
         end
      end
   end

endmodule

// File: rtl/fir_decimator_fifo.sv
// -----------------------------------------------------------------------------
// fir_decimator_fifo
//   Decimates the FIR output stream by DECIM and queues the decimated samples
//   for a slower consumer behind a valid/ready handshake.
//   Ports:
//     clock, nreset        rising-edge clock, asynchronous active-low reset
//     xn, xn_en            FIR sample and its strobe (no backpressure upstream)
//     yn, yn_valid         FIFO head and not-empty flag
//     yn_ready             consumer accepts yn on this edge
//     level                FIFO occupancy 0..DEPTH
//     ovf, ovf_clr         sticky drop flag and its clear (a drop wins)
//   Build option:
//     FIR_DECIM_AVG_EN     defined: push the boxcar average of each group
//                          undefined: push the last sample of each group
// -----------------------------------------------------------------------------
module fir_decimator_fifo
   import fir_pkg::*;
#(
   parameter int WIDTH = FIR_WIDTH,
   parameter int DECIM = 4,
   parameter int DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     nreset,
   input  logic [WIDTH-1:0]         xn,
   input  logic                     xn_en,
   output logic [WIDTH-1:0]         yn,
   output logic                     yn_valid,
   input  logic                     yn_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ovf,
   input  logic                     ovf_clr
);

   localparam int PW = $clog2(DECIM);

   generate
      if (!is_pow2_ge2(DECIM)) begin : g_bad_decim
         $error("fir_decimator_fifo: DECIM must be a power of two >= 2");
      end
      if (!is_pow2_ge2(DEPTH)) begin : g_bad_depth
         $error("fir_decimator_fifo: DEPTH must be a power of two >= 2");
      end
   endgenerate

   logic [PW-1:0]    phase;
   logic             produce, pop, drop;
   logic             full, empty;
   logic [WIDTH-1:0] push_data;

   assign produce  = xn_en && (phase == PW'(DECIM - 1));
   assign yn_valid = ~empty;
   assign pop      = yn_valid & yn_ready;
   assign drop     = produce & full & ~pop;

   // DECIM is a power of two, so the natural wrap gives DECIM-1 -> 0.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset)    phase <= '0;
      else if (xn_en) phase <= phase + 1'b1;
   end

`ifdef FIR_DECIM_AVG_EN
   // Wide enough for DECIM full-scale samples, so the sum never wraps.
   logic [WIDTH+PW-1:0] acc, acc_sum;

   assign acc_sum   = acc + {{PW{1'b0}}, xn};
   assign push_data = acc_sum[WIDTH+PW-1:PW];

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset)    acc <= '0;
      else if (xn_en) acc <= (phase == '0) ? {{PW{1'b0}}, xn} : acc_sum;
   end
`else
   assign push_data = xn;
`endif

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset)      ovf <= 1'b0;
      else if (drop)    ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
   end

   sample_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .nreset  (nreset),
      .push    (produce),
      .wr_data (push_data),
      .pop     (pop),
      .rd_data (yn),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

endmodule

// File: tb/tb_fir_decimator_fifo.sv
module tb_fir_decimator_fifo;

`ifdef FIR_DECIM_AVG_EN
   localparam bit AVG = 1'b1;
`else
   localparam bit AVG = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       nreset;
   logic [7:0] xn;
   logic       xn_en;
   logic [7:0] yn;
   logic       yn_valid;
   logic       yn_ready;
   logic [3:0] level;
   logic       ovf;
   logic       ovf_clr;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   fir_decimator_fifo dut (
      .clock    (clock),
      .nreset   (nreset),
      .xn       (xn),
      .xn_en    (xn_en),
      .yn       (yn),
      .yn_valid (yn_valid),
      .yn_ready (yn_ready),
      .level    (level),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
   );

   // One clock of stimulus and the state expected right after that edge.
   typedef struct {
      logic [7:0] xn;
      logic       en;
      logic       rdy;
      logic       clr;
      logic       ev;
      logic [7:0] ey;
      logic [3:0] el;
      logic       eo;
   } vec_t;

   vec_t vecs[$];

   // Outputs for xn = 1..N: group g holds 4g+1..4g+4 (last = 4g+4, floor avg = 4g+2).
   function automatic logic [7:0] vexp(input int g);
      return AVG ? 8'(4*g + 2) : 8'(4*g + 4);
   endfunction
   // Outputs for xn = 101..: group g holds 101+4g..104+4g (avg floor = 102+4g).
   function automatic logic [7:0] wexp(input int g);
      return AVG ? 8'(102 + 4*g) : 8'(104 + 4*g);
   endfunction

   task automatic add(input int x, input bit en, input bit rdy, input bit clr,
                      input bit ev, input int ey, input int el, input bit eo);
      vec_t v;
      v.xn = 8'(x); v.en = en; v.rdy = rdy; v.clr = clr;
      v.ev = ev; v.ey = 8'(ey); v.el = 4'(el); v.eo = eo;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input int idx, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0d, want %0d", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input int x, input bit en, input bit rdy, input bit clr);
      @(negedge clock);
      xn = 8'(x); xn_en = en; yn_ready = rdy; ovf_clr = clr;
      @(posedge clock);
      #1;
   endtask

   initial begin
      int p;
      int t2;
      int t6;
      t2 = AVG ? 25 : 40;
      t6 = AVG ? 65 : 80;

      // 1: continuous stream 1..16, consumer always ready.
      for (int i = 1; i <= 16; i++) begin
         p = i / 4;
         if (i % 4 == 0) add(i, 1, 1, 0, 1, vexp(p-1), 1, 0);
         else            add(i, 1, 1, 0, 0, (p == 0) ? 0 : vexp(p-1), 0, 0);
      end
      add(0, 0, 1, 0, 0, vexp(3), 0, 0);

      // 2: gapped stream; disabled cycles carry junk that must be ignored.
      add(10, 1, 1, 0, 0, vexp(3), 0, 0);
      add(99, 0, 1, 0, 0, vexp(3), 0, 0);
      add(20, 1, 1, 0, 0, vexp(3), 0, 0);
      add(99, 0, 1, 0, 0, vexp(3), 0, 0);
      add(30, 1, 1, 0, 0, vexp(3), 0, 0);
      add(99, 0, 1, 0, 0, vexp(3), 0, 0);
      add(40, 1, 1, 0, 1, t2, 1, 0);
      add(99, 0, 1, 0, 0, t2, 0, 0);

      // 3: consumer stalled for 10 produce events -> fill, two drops, ovf.
      for (int i = 1; i <= 40; i++) begin
         p = i / 4;
         add(i, 1, 0, 0, p > 0, (p > 0) ? vexp(0) : t2, (p > 8) ? 8 : p, p >= 9);
      end
      for (int j = 0; j < 8; j++)
         add(0, 0, 1, 0, j < 7, (j < 7) ? vexp(j+1) : vexp(7), 7 - j, 1);

      // 5a: clear with no drop.
      add(0, 0, 0, 1, 0, vexp(7), 0, 0);

      // 4: refill to full, then produce and pop on the same edge.
      for (int i = 1; i <= 35; i++) begin
         p = i / 4;
         add(100 + i, 1, 0, 0, p > 0, (p > 0) ? wexp(0) : vexp(7), (p > 8) ? 8 : p, 0);
      end
      add(136, 1, 1, 0, 1, wexp(1), 8, 0);

      // 5b: clear on the same edge as a drop -> set wins.
      add(137, 1, 0, 0, 1, wexp(1), 8, 0);
      add(138, 1, 0, 0, 1, wexp(1), 8, 0);
      add(139, 1, 0, 0, 1, wexp(1), 8, 0);
      add(140, 1, 0, 1, 1, wexp(1), 8, 1);
      add(0, 0, 0, 0, 1, wexp(1), 8, 1);
      // Drain: the sample pushed during the full+pop edge is last.
      for (int j = 0; j < 8; j++)
         add(0, 0, 1, 0, j < 7, (j < 7) ? wexp(j+2) : wexp(8), 7 - j, 1);
      add(0, 0, 0, 1, 0, wexp(8), 0, 0);

      // Reset state.
      nreset = 1'b0; xn = '0; xn_en = 1'b0; yn_ready = 1'b0; ovf_clr = 1'b0;
      #12;
      check("rst_valid", 0, int'(yn_valid), 0);
      check("rst_yn",    0, int'(yn),       0);
      check("rst_level", 0, int'(level),    0);
      check("rst_ovf",   0, int'(ovf),      0);
      @(negedge clock);
      nreset = 1'b1;

      foreach (vecs[i]) begin
         drive(int'(vecs[i].xn), vecs[i].en, vecs[i].rdy, vecs[i].clr);
         check("yn_valid", i, int'(yn_valid), int'(vecs[i].ev));
         check("yn",       i, int'(yn),       int'(vecs[i].ey));
         check("level",    i, int'(level),    int'(vecs[i].el));
         check("ovf",      i, int'(ovf),      int'(vecs[i].eo));
      end

      // 6: reset mid-group (phase 2) with 3 entries queued.
      for (int i = 1; i <= 14; i++) drive(i, 1, 0, 0);
      check("pre_rst_level", 0, int'(level),    3);
      check("pre_rst_yn",    0, int'(yn),       int'(vexp(0)));
      #2;
      nreset = 1'b0;
      #1;
      check("mid_rst_valid", 0, int'(yn_valid), 0);
      check("mid_rst_yn",    0, int'(yn),       0);
      check("mid_rst_level", 0, int'(level),    0);
      check("mid_rst_ovf",   0, int'(ovf),      0);
      @(negedge clock);
      xn_en = 1'b0;
      nreset = 1'b1;
      drive(50, 1, 0, 0);
      check("post_rst_valid", 1, int'(yn_valid), 0);
      drive(60, 1, 0, 0);
      check("post_rst_valid", 2, int'(yn_valid), 0);
      drive(70, 1, 0, 0);
      check("post_rst_valid", 3, int'(yn_valid), 0);
      drive(80, 1, 0, 0);
      check("post_rst_valid", 4, int'(yn_valid), 1);
      check("post_rst_yn",    4, int'(yn),       t6);
      check("post_rst_level", 4, int'(level),    1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
